// File: rtl/sha3_busin_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : iSha3_1600_BusIn
//  Description : 1600-bit SHA3 state bus. Twenty-five 64-bit lanes in five
//                rows (ina..ine) and a single-cycle sample strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
interface iSha3_1600_BusIn;
  logic             sample;
  logic [4:0][63:0] ina;
  logic [4:0][63:0] inb;
  logic [4:0][63:0] inc;
  logic [4:0][63:0] ind;
  logic [4:0][63:0] ine;

  // Loader side drives the state, the permutation core consumes it
  modport controller (output sample, ina, inb, inc, ind, ine);
  modport target     (input  sample, ina, inb, inc, ind, ine);
endinterface
`default_nettype wire

// File: rtl/sha3_busin_loader.sv
`default_nettype none
// ============================================================================
//  Module      : sha3_busin_loader
//  Description : Collects 25 streamed 64-bit lanes into a 1600-bit SHA3
//                state, then presents it on the BusIn interface with a
//                one-cycle sample strobe once the core is ready.
//                Optional macro SHA3_LOADER_ZEROFILL_EN: in_last ends a block
//                early and zeroes the remaining lanes.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha3_busin_loader (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [63:0]                 in_lane,
  input  logic                        in_last,
  input  logic                        out_ready,
  iSha3_1600_BusIn.controller         busout,
  output logic [4:0]                  lanes_loaded
);

  localparam logic [0:0] c_FILL     = 1'b0;
  localparam logic [0:0] c_HOLD     = 1'b1;
  localparam logic [4:0] c_LAST_IDX = 5'd24;
  localparam logic [4:0] c_FULL     = 5'd25;

  logic [0:0]        state_q, state_d;
  logic [4:0]        cnt_q,   cnt_d;
  logic [24:0][63:0] lanes_q, lanes_d;
  logic              w_early_end;

`ifdef SHA3_LOADER_ZEROFILL_EN
  assign w_early_end = in_last;
`else
  // in_last has no meaning in this build; tie it off explicitly
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign w_early_end    = 1'b0;
`endif

  // Next-state: capture lanes in FILL, release the block in HOLD
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lanes_d = lanes_q;
    if (state_q == c_FILL) begin
      if (in_valid) begin
        lanes_d[cnt_q] = in_lane;
        if ((cnt_q == c_LAST_IDX) || w_early_end) begin
`ifdef SHA3_LOADER_ZEROFILL_EN
          // Pad the unsent tail of the block with zero lanes
          for (int i = 0; i < 25; i++) begin
            if (5'(i) > cnt_q) begin
              lanes_d[i] = '0;
            end
          end
`endif
          cnt_d   = c_FULL;
          state_d = c_HOLD;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
    end else begin
      // Stale lanes stay in place; only the counter restarts
      if (out_ready) begin
        state_d = c_FILL;
        cnt_d   = '0;
      end
    end
  end

  // State, counter and lane registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_FILL;
      cnt_q   <= '0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lanes_q <= lanes_d;
    end
  end

  assign in_ready       = (state_q == c_FILL);
  assign lanes_loaded   = cnt_q;
  assign busout.sample  = (state_q == c_HOLD) && out_ready;
  assign busout.ina     = lanes_q[4:0];
  assign busout.inb     = lanes_q[9:5];
  assign busout.inc     = lanes_q[14:10];
  assign busout.ind     = lanes_q[19:15];
  assign busout.ine     = lanes_q[24:20];

endmodule
`default_nettype wire

// File: tb/tb_sha3_busin_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha3_busin_loader
//  Description : Self-checking bench for sha3_busin_loader. Keeps its own
//                picture of the 25-lane state and the lane count and compares
//                the bus against it after every step.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sha3_busin_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_lane;
  logic        in_last;
  logic        out_ready;
  logic [4:0]  lanes_loaded;

  iSha3_1600_BusIn bus ();

  sha3_busin_loader dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_lane      (in_lane),
    .in_last      (in_last),
    .out_ready    (out_ready),
    .busout       (bus),
    .lanes_loaded (lanes_loaded)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_lane [25];
  int          exp_cnt;

  // Single comparison point
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] bus_lane(input int k);
    case (k / 5)
      0:       return bus.ina[k % 5];
      1:       return bus.inb[k % 5];
      2:       return bus.inc[k % 5];
      3:       return bus.ind[k % 5];
      default: return bus.ine[k % 5];
    endcase
  endfunction

  task automatic chk_all_lanes(input string tag);
    for (int k = 0; k < 25; k++)
      chk($sformatf("%s_lane%0d", tag, k), bus_lane(k), exp_lane[k]);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 25; k++) exp_lane[k] = '0;
    exp_cnt = 0;
  endtask

  // One lane transfer; called at a negedge, returns at the next negedge
  task automatic xfer(input logic [63:0] v, input logic last);
    in_valid = 1'b1;
    in_lane  = v;
    in_last  = last;
    #1;
    chk("in_ready_fill", {63'd0, in_ready}, 64'd1);
    chk("sample_fill", {63'd0, bus.sample}, 64'd0);
    @(negedge clk);
    exp_lane[exp_cnt] = v;
`ifdef SHA3_LOADER_ZEROFILL_EN
    if (last && exp_cnt < 24) begin
      for (int k = exp_cnt + 1; k < 25; k++) exp_lane[k] = '0;
      exp_cnt = 24;
    end
`endif
    exp_cnt++;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("lanes_loaded_xfer", {59'd0, lanes_loaded}, 64'(exp_cnt));
  endtask

  // A cycle with no offered lane
  task automatic idle();
    in_valid = 1'b0;
    in_lane  = {$urandom, $urandom};
    in_last  = 1'($urandom);
    @(negedge clk);
    chk("lanes_loaded_idle", {59'd0, lanes_loaded}, 64'(exp_cnt));
  endtask

  // Full block pending: wait n cycles with out_ready low, then release it
  task automatic hold_release(input int waits);
    for (int w = 0; w < waits; w++) begin
      out_ready = 1'b0;
      #1;
      chk("hold_sample_low", {63'd0, bus.sample}, 64'd0);
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      chk("hold_lanes_loaded", {59'd0, lanes_loaded}, 64'd25);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("sample_high", {63'd0, bus.sample}, 64'd1);
    chk("sample_in_ready", {63'd0, in_ready}, 64'd0);
    chk("sample_lanes_loaded", {59'd0, lanes_loaded}, 64'd25);
    chk_all_lanes("sample");
    @(negedge clk);
    exp_cnt = 0;
    chk("post_sample_low", {63'd0, bus.sample}, 64'd0);
    chk("post_in_ready", {63'd0, in_ready}, 64'd1);
    chk("post_lanes_loaded", {59'd0, lanes_loaded}, 64'd0);
    chk("post_stale_lane0", bus_lane(0), exp_lane[0]);
    chk("post_stale_lane24", bus_lane(24), exp_lane[24]);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_clear();
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, "_lanes_loaded"}, {59'd0, lanes_loaded}, 64'd0);
    chk({tag, "_sample"}, {63'd0, bus.sample}, 64'd0);
    chk_all_lanes(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_lane = '0; in_last = 1'b0; out_ready = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    do_reset("reset");

    // Back-to-back 0x1..0x19, lane 0 accepted on the first edge after reset
    for (int k = 0; k < 25; k++) xfer(64'(k + 1), 1'b0);
    hold_release(0);
    chk("map_ina0", bus.ina[0], 64'h1);
    chk("map_ine4", bus.ine[4], 64'h19);

    // Pending block held for 10 cycles, next lane 0 right after the sample
    out_ready = 1'b0;
    for (int k = 0; k < 25; k++) xfer({$urandom, $urandom}, 1'b0);
    hold_release(10);
    out_ready = 1'b0;
    xfer(64'hDEAD_BEEF_0000_0000, 1'b0);

    // Gapped stream of tagged lanes
    for (int k = 1; k < 25; k++) begin
      idle();
      xfer(64'hA5A5_0000_0000_0000 | 64'(k), 1'b0);
    end
    hold_release(2);

    // Reset after lane 12, then a fresh block
    for (int k = 0; k < 13; k++) xfer({$urandom, $urandom}, 1'b0);
    out_ready = 1'b1;
    do_reset("rst_mid");
    #1;
    chk("rst_mid_no_sample", {63'd0, bus.sample}, 64'd0);
    out_ready = 1'b0;
    for (int k = 0; k < 25; k++) xfer(64'hF00D_0000_0000_0000 | 64'(k), 1'b0);
    hold_release(1);

    // Reset while a full block is pending
    out_ready = 1'b0;
    for (int k = 0; k < 25; k++) xfer({$urandom, $urandom}, 1'b0);
    do_reset("rst_hold");
    out_ready = 1'b1;
    #1;
    chk("rst_hold_no_sample", {63'd0, bus.sample}, 64'd0);
    @(negedge clk);
    chk("rst_hold_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_hold_cnt", {59'd0, lanes_loaded}, 64'd0);
    out_ready = 1'b0;

    // All-ones block, then a block flagged last on lane 6
    for (int k = 0; k < 25; k++) xfer(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    hold_release(0);
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) xfer({$urandom, $urandom}, k == 6);
`ifdef SHA3_LOADER_ZEROFILL_EN
    chk("zf_cnt", {59'd0, lanes_loaded}, 64'd25);
    chk("zf_inb2", bus.inb[2], 64'd0);
    chk("zf_ine4", bus.ine[4], 64'd0);
    hold_release(1);
`else
    chk("nozf_cnt", {59'd0, lanes_loaded}, 64'd7);
    chk("nozf_in_ready", {63'd0, in_ready}, 64'd1);
    chk("nozf_stale_inb2", bus.inb[2], 64'hFFFF_FFFF_FFFF_FFFF);
    for (int k = 7; k < 25; k++) xfer({$urandom, $urandom}, 1'($urandom));
    hold_release(1);
`endif

    // Randomised blocks: random gaps, random in_last, random release delay
    for (int b = 0; b < 4; b++) begin
      out_ready = 1'b0;
      while (exp_cnt < 25) begin
        if ($urandom_range(0, 3) == 0) idle();
        else xfer({$urandom, $urandom}, $urandom_range(0, 7) == 0);
      end
      hold_release(int'($urandom_range(0, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
